// File: rtl/midori_sbox_layer_ctrl_if.sv
// midori_sbox_layer_ctrl_if: host-side start/state-share bus of the S-box layer sequencer
interface midori_sbox_layer_ctrl_if;
    logic        start;
    logic [63:0] s1_in, s2_in, s3_in;
    logic [63:0] s1_out, s2_out, s3_out;
    logic        busy, done;
    modport master(output start, s1_in, s2_in, s3_in, input s1_out, s2_out, s3_out, busy, done);
    modport slave(input start, s1_in, s2_in, s3_in, output s1_out, s2_out, s3_out, busy, done);
endinterface

// File: rtl/midori_sbox_layer_ctrl.sv
// midori_sbox_layer_ctrl: streams three 64-bit shares nibble-by-nibble through a shared TI S-box core
module midori_sbox_layer_ctrl #(
    parameter int SB_LAT = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    midori_sbox_layer_ctrl_if.slave        bus,
    output logic [3:0]                     sb_x1,
    output logic [3:0]                     sb_x2,
    output logic [3:0]                     sb_x3,
    output logic                           sb_en,
    input  logic [3:0]                     sb_y1,
    input  logic [3:0]                     sb_y2,
    input  logic [3:0]                     sb_y3
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [4:0]  fc_q, fc_d;
    logic [3:0]  wc_q, wc_d;
    logic [63:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic        feed, wr;
    logic [5:0]  fpos, wpos;
    // nibble (15-n) starts at bit 4*(~n); feeding stops once fc reaches 16
    assign fpos = {~fc_q[3:0], 2'b00};
    assign wpos = {~wc_q, 2'b00};
    assign feed = (state_q == RUN) && !fc_q[4];
    generate
        if (SB_LAT == 0) begin : g_comb
            assign wr = feed;
        end else begin : g_pipe
            logic [SB_LAT-1:0] v_q, v_d;
            logic [SB_LAT:0]   v_all;
            assign v_all = {v_q, feed};
            assign wr    = v_all[SB_LAT];
            // valid shift register tracks which core output slots carry a fed nibble
            always_comb v_d = (state_q == RUN) ? v_all[SB_LAT-1:0] : '0;
            // valid register, cleared outside RUN so each layer starts empty
            always_ff @(posedge clk or posedge rst)
                if (rst) v_q <= '0;
                else     v_q <= v_d;
        end
    endgenerate
    // next-state: load on start outside RUN, otherwise advance feed and write-back
    always_comb begin
        state_d = state_q;
        fc_d    = fc_q;
        wc_d    = wc_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        s3_d    = s3_q;
        if (state_q != RUN) begin
            state_d = bus.start ? RUN : IDLE;
            if (bus.start) begin
                fc_d = '0;
                wc_d = '0;
                s1_d = bus.s1_in;
                s2_d = bus.s2_in;
                s3_d = bus.s3_in;
            end
        end else begin
            fc_d = feed ? fc_q + 5'd1 : fc_q;
            if (wr) begin
                s1_d[wpos +: 4] = sb_y1;
                s2_d[wpos +: 4] = sb_y2;
                s3_d[wpos +: 4] = sb_y3;
                wc_d            = wc_q + 4'd1;
                state_d         = (wc_q == 4'd15) ? DONE : RUN;
            end
        end
    end
    // state, counters and share registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            fc_q    <= '0;
            wc_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
            wc_q    <= wc_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
        end
    assign sb_x1      = feed ? s1_q[fpos +: 4] : '0;
    assign sb_x2      = feed ? s2_q[fpos +: 4] : '0;
    assign sb_x3      = feed ? s3_q[fpos +: 4] : '0;
    assign sb_en      = state_q == RUN;
    assign bus.busy   = state_q == RUN;
    assign bus.done   = state_q == DONE;
    assign bus.s1_out = s1_q;
    assign bus.s2_out = s2_q;
    assign bus.s3_out = s3_q;
endmodule

// File: tb/tb_midori_sbox_layer_ctrl.sv
// tb_midori_sbox_layer_ctrl: vector table plus corner sequences on SB_LAT=0,3,7 builds
module tb_midori_sbox_layer_ctrl;
    logic clk = 1'b0;
    logic rst, start;
    logic [63:0] i1, i2, i3;
    int pass_n = 0, tot_n = 0;
    always #5 clk = ~clk;
    midori_sbox_layer_ctrl_if h0(), h3(), h7();
    assign h0.start = start; assign h0.s1_in = i1; assign h0.s2_in = i2; assign h0.s3_in = i3;
    assign h3.start = start; assign h3.s1_in = i1; assign h3.s2_in = i2; assign h3.s3_in = i3;
    assign h7.start = start; assign h7.s1_in = i1; assign h7.s2_in = i2; assign h7.s3_in = i3;
    logic [2:0][3:0] x1, x2, x3, y1, y2, y3;
    logic [2:0] en;
    midori_sbox_layer_ctrl #(.SB_LAT(0)) d0 (.clk(clk), .rst(rst), .bus(h0.slave),
        .sb_x1(x1[0]), .sb_x2(x2[0]), .sb_x3(x3[0]), .sb_en(en[0]), .sb_y1(y1[0]), .sb_y2(y2[0]), .sb_y3(y3[0]));
    midori_sbox_layer_ctrl #(.SB_LAT(3)) d3 (.clk(clk), .rst(rst), .bus(h3.slave),
        .sb_x1(x1[1]), .sb_x2(x2[1]), .sb_x3(x3[1]), .sb_en(en[1]), .sb_y1(y1[1]), .sb_y2(y2[1]), .sb_y3(y3[1]));
    midori_sbox_layer_ctrl #(.SB_LAT(7)) d7 (.clk(clk), .rst(rst), .bus(h7.slave),
        .sb_x1(x1[2]), .sb_x2(x2[2]), .sb_x3(x3[2]), .sb_en(en[2]), .sb_y1(y1[2]), .sb_y2(y2[2]), .sb_y3(y3[2]));

    function automatic logic [3:0] sb0(input logic [3:0] x);
        logic [63:0] t;
        t = 64'hCAD3EBF789150246;
        return t[{~x, 2'b00} +: 4];
    endfunction
    function automatic logic [11:0] core(input logic [3:0] a, b, c);
        logic [3:0] s;
        s = sb0(a ^ b ^ c);
        return {s ^ b ^ c, b, c};
    endfunction
    function automatic logic [63:0] layer(input logic [63:0] st);
        logic [63:0] r;
        for (int k = 0; k < 16; k++) r[4*k +: 4] = sb0(st[4*k +: 4]);
        return r;
    endfunction

    assign {y1[0], y2[0], y3[0]} = core(x1[0], x2[0], x3[0]);
    logic [11:0] p3[3], p7[7];
    always_ff @(posedge clk)
        if (en[1]) begin
            p3[0] <= core(x1[1], x2[1], x3[1]);
            for (int i = 1; i < 3; i++) p3[i] <= p3[i-1];
        end
    always_ff @(posedge clk)
        if (en[2]) begin
            p7[0] <= core(x1[2], x2[2], x3[2]);
            for (int i = 1; i < 7; i++) p7[i] <= p7[i-1];
        end
    assign {y1[1], y2[1], y3[1]} = p3[2];
    assign {y1[2], y2[2], y3[2]} = p7[6];

    logic [63:0]  sum_v[3];
    logic [206:0] all_v[3];
    logic [2:0]   done_v, busy_v, leak_v;
    assign sum_v[0] = h0.s1_out ^ h0.s2_out ^ h0.s3_out;
    assign sum_v[1] = h3.s1_out ^ h3.s2_out ^ h3.s3_out;
    assign sum_v[2] = h7.s1_out ^ h7.s2_out ^ h7.s3_out;
    assign all_v[0] = {h0.s1_out, h0.s2_out, h0.s3_out, h0.busy, h0.done, en[0], x1[0], x2[0], x3[0]};
    assign all_v[1] = {h3.s1_out, h3.s2_out, h3.s3_out, h3.busy, h3.done, en[1], x1[1], x2[1], x3[1]};
    assign all_v[2] = {h7.s1_out, h7.s2_out, h7.s3_out, h7.busy, h7.done, en[2], x1[2], x2[2], x3[2]};
    assign done_v = {h7.done, h3.done, h0.done};
    assign busy_v = {h7.busy, h3.busy, h0.busy};
    for (genvar g = 0; g < 3; g++) begin : g_leak
        assign leak_v[g] = !busy_v[g] && (en[g] || {x1[g], x2[g], x3[g]} != 12'd0);
    end

    int lat[3] = '{16, 19, 23};
    int dn[3];
    int dn2, blow;
    logic [63:0] xseq;
    logic leak;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // mode 0 normal, 1 extra start at E7, 2 reset at E5, 3 start held through done
    task automatic run_layer(input logic [63:0] a, b, c, input int mode);
        for (int j = 0; j < 3; j++) dn[j] = -1;
        dn2 = -1; blow = 0; xseq = '0; leak = 1'b0;
        @(negedge clk);
        i1 = a; i2 = b; i3 = c; start = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (done_v[1] && dn[1] >= 0 && n > dn[1] && dn2 < 0) dn2 = n;
            for (int j = 0; j < 3; j++) if (done_v[j] && dn[j] < 0) dn[j] = n;
            if (dn[1] >= 0 && dn2 < 0 && !busy_v[1]) blow++;
            if (leak_v != 3'b000) leak = 1'b1;
            if (n < 16) xseq = {xseq[59:0], x1[1]};
            start = (mode == 1 && n == 6) || (mode == 3 && (dn[1] < 0 || dn[1] == n));
            if (mode == 1 && n == 6) begin
                i1 = ~a; i2 = ~b; i3 = ~c;
            end
            if (mode == 3 && dn[1] == n) begin
                i1 = h3.s1_out; i2 = h3.s2_out; i3 = h3.s3_out;
            end
            if (mode == 2 && n == 4) begin
                @(posedge clk);
                #1 rst = 1'b1;
                #1 for (int j = 0; j < 3; j++) chk($sformatf("rst_async_d%0d", j), 256'(all_v[j]), 256'd0);
            end
            if (mode == 2 && n == 8) rst = 1'b0;
        end
    endtask

    typedef struct {
        logic [63:0] st, s2, s3, exp;
        int mode;
    } vec_t;
    vec_t tv[6];

    initial begin
        rst = 1'b1; start = 1'b0; i1 = '0; i2 = '0; i3 = '0;
        repeat (3) @(negedge clk);
        for (int j = 0; j < 3; j++) chk($sformatf("reset_d%0d", j), 256'(all_v[j]), 256'd0);
        rst = 1'b0;
        tv[0] = '{64'h0123456789ABCDEF, 64'h0, 64'h0, 64'hCAD3EBF789150246, 0};
        tv[1] = '{64'h0123456789ABCDEF, {$urandom, $urandom}, {$urandom, $urandom}, 64'hCAD3EBF789150246, 0};
        tv[2] = '{64'h0, 64'h5A5A_0F0F_3C3C_9696, 64'hFFFF_0000_1234_8001, 64'hCCCCCCCCCCCCCCCC, 0};
        tv[3] = '{64'hFEDCBA9876543210, {$urandom, $urandom}, {$urandom, $urandom}, 64'h642051987FBE3DAC, 0};
        tv[4] = '{64'h0123456789ABCDEF, 64'hDEAD_BEEF_0BAD_F00D, 64'h1357_9BDF_2468_ACE0, 64'hCAD3EBF789150246, 1};
        tv[5] = '{64'h0123456789ABCDEF, 64'h0F1E_2D3C_4B5A_6978, 64'h8877_6655_4433_2211, 64'h0123456789ABCDEF, 3};
        for (int t = 0; t < 6; t++) begin
            logic [63:0] s1v;
            s1v = tv[t].st ^ tv[t].s2 ^ tv[t].s3;
            run_layer(s1v, tv[t].s2, tv[t].s3, tv[t].mode);
            chk($sformatf("xseq_v%0d", t), 256'(xseq), 256'(s1v));
            chk($sformatf("leak_v%0d", t), 256'(leak), 256'd0);
            if (tv[t].mode == 3) begin
                chk("b2b_first_done", 256'(dn[1]), 256'd19);
                chk("b2b_second_done", 256'(dn2), 256'd39);
                chk("b2b_busy_low", 256'(blow), 256'd1);
                chk("b2b_result", 256'(sum_v[1]), 256'(tv[t].exp));
            end else begin
                for (int j = 0; j < 3; j++) begin
                    chk($sformatf("result_v%0d_d%0d", t, j), 256'(sum_v[j]), 256'(tv[t].exp));
                    chk($sformatf("done_lat_v%0d_d%0d", t, j), 256'(dn[j]), 256'(lat[j]));
                end
            end
        end
        run_layer(64'h0123456789ABCDEF, 64'h0, 64'h0, 2);
        for (int j = 0; j < 3; j++) chk($sformatf("no_done_after_rst_d%0d", j), 256'(dn[j] < 0), 256'd1);
        run_layer(64'hFEDCBA9876543210 ^ 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 64'h0, 0);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("post_rst_result_d%0d", j), 256'(sum_v[j]), 256'(layer(64'hFEDCBA9876543210)));
            chk($sformatf("post_rst_lat_d%0d", j), 256'(dn[j]), 256'(lat[j]));
        end
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
